// File: rtl/mv_pkg.sv
// mv_pkg: shared constants, command encodings, FSM state type and the
// reset-value helper for the mat_vec_mult coefficient loader.
//   N, W        : matrix dimension and coefficient width
//   NUM_COEF    : number of coefficients in one full load (N*N)
//   CNT_W       : width of the coefficient counter (counts 0..NUM_COEF)
//   MAT_W       : width of the flattened matrix bus
package mv_pkg;

  localparam int N        = 2;
  localparam int W        = 4;
  localparam int NUM_COEF = N * N;
  localparam int CNT_W    = $clog2(NUM_COEF + 1);
  localparam int MAT_W    = NUM_COEF * W;

  // Counter value meaning "every coefficient has been written".
  localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(NUM_COEF);

  typedef enum logic [1:0] {
    CMD_DATA   = 2'b00,
    CMD_START  = 2'b01,
    CMD_COMMIT = 2'b10,
    CMD_ABORT  = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // Identity matrix in the flattened layout: element (r,c) at [(r*N+c)*W +: W].
  // Used as the reset value so the multiplier passes its vector through.
  function automatic logic [MAT_W-1:0] identity_matrix();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      m[(r * N + r) * W +: W] = W'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings an asynchronous strobe and its companion data bus
// into the clk domain and emits a one-cycle pulse per strobe rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   strobe_in  : raw strobe pin
//   data_in    : raw data pins qualified by the strobe (WIDTH bits)
//   pulse      : registered one-cycle pulse, one per strobe rising edge
//   data_out   : data taken from the same synchronizer stage as the strobe
module sync_edge_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             pulse,
  output logic [WIDTH-1:0] data_out
);

  logic             strb_s1;
  logic             strb_s2;
  logic             strb_prev;
  logic [WIDTH-1:0] data_s1;
  logic [WIDTH-1:0] data_s2;

  // Two flops of synchronization for strobe and data alike, then an edge
  // detector on the second stage. The pulse and its data are registered
  // together so the consumer sees them aligned in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1   <= 1'b0;
      strb_s2   <= 1'b0;
      strb_prev <= 1'b0;
      data_s1   <= '0;
      data_s2   <= '0;
      pulse     <= 1'b0;
      data_out  <= '0;
    end else begin
      strb_s1   <= strobe_in;
      strb_s2   <= strb_s1;
      strb_prev <= strb_s2;
      data_s1   <= data_in;
      data_s2   <= data_s1;
      pulse     <= strb_s2 & ~strb_prev;
      data_out  <= data_s2;
    end
  end

endmodule

// File: rtl/mv_coef_loader.sv
// mv_coef_loader: writer side of the mat_vec_mult coefficient interface.
// Decodes strobed commands from the pins, assembles coefficients in a shadow
// register file and atomically copies them to the live matrix on COMMIT.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : when low, decoded events are discarded
//   strobe_in    : raw strobe pin, one event per rising edge
//   cmd_in       : raw command pins (DATA/START/COMMIT/ABORT)
//   data_in      : raw coefficient pins
//   matrix_out   : live matrix, element (r,c) at [(r*N+c)*W +: W]
//   matrix_valid : set once any commit has succeeded since reset
//   busy         : high while a load is in progress
//   err          : sticky protocol error, cleared by START or reset
//   load_count   : coefficients written in the current (or last) load
module mv_coef_loader
  import mv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             strobe_in,
  input  logic [1:0]       cmd_in,
  input  logic [W-1:0]     data_in,
  output logic [MAT_W-1:0] matrix_out,
  output logic             matrix_valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] load_count
);

  logic             ev_pulse;
  logic [W+1:0]     ev_data;
  cmd_e             ev_cmd;
  logic [W-1:0]     ev_coef;

  state_e           state;
  logic [CNT_W-1:0] idx;
  logic [MAT_W-1:0] shadow;

  sync_edge_det #(
    .WIDTH(W + 2)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe_in (strobe_in),
    .data_in   ({cmd_in, data_in}),
    .pulse     (ev_pulse),
    .data_out  (ev_data)
  );

  assign ev_cmd  = cmd_e'(ev_data[W+1:W]);
  assign ev_coef = ev_data[W-1:0];

  assign busy       = (state == ST_LOAD);
  assign load_count = idx;

  // Command FSM and register file. The live matrix only changes on a
  // complete COMMIT, so the multiplier never sees a half-written matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      shadow       <= '0;
      matrix_out   <= identity_matrix();
      matrix_valid <= 1'b0;
      err          <= 1'b0;
    end else if (ev_pulse && ena) begin
      case (ev_cmd)
        CMD_START: begin
          state  <= ST_LOAD;
          idx    <= '0;
          shadow <= '0;
          err    <= 1'b0;
        end
        CMD_DATA: begin
          if (state == ST_LOAD) begin
            if (idx == FULL_IDX) begin
              err <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_COEF; i++) begin
                if (idx == CNT_W'(i)) begin
                  shadow[i * W +: W] <= ev_coef;
                end
              end
              idx <= idx + CNT_W'(1);
            end
          end
        end
        CMD_COMMIT: begin
          state <= ST_IDLE;
          if (state == ST_LOAD && idx == FULL_IDX) begin
            matrix_out   <= shadow;
            matrix_valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        CMD_ABORT: begin
          state  <= ST_IDLE;
          shadow <= '0;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mv_coef_loader.sv
// tb_mv_coef_loader: directed self-checking bench for mv_coef_loader.
// Drives the pin protocol (setup, strobe, hold) and compares every output
// against hand-computed values with immediate assertions.
module tb_mv_coef_loader;
  import mv_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             strobe_in;
  logic [1:0]       cmd_in;
  logic [W-1:0]     data_in;
  logic [MAT_W-1:0] matrix_out;
  logic             matrix_valid;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] load_count;

  int checks   = 0;
  int failures = 0;

  mv_coef_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .strobe_in    (strobe_in),
    .cmd_in       (cmd_in),
    .data_in      (data_in),
    .matrix_out   (matrix_out),
    .matrix_valid (matrix_valid),
    .busy         (busy),
    .err          (err),
    .load_count   (load_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present cmd/data, hold them 2 clk, then raise the strobe just after an edge.
  task automatic raise_strobe(input logic [1:0] cmd, input logic [W-1:0] data);
    cmd_in  = cmd;
    data_in = data;
    repeat (2) @(posedge clk);
    #1 strobe_in = 1'b1;
  endtask

  // Full event: returns 4 edges after the strobe rise, where the effect is visible.
  task automatic apply_stimulus(input logic [1:0] cmd, input logic [W-1:0] data);
    raise_strobe(cmd, data);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Drop the strobe and keep cmd/data steady while it stays low.
  task automatic release_strobe();
    strobe_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [W-1:0] data);
    apply_stimulus(cmd, data);
    release_strobe();
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    strobe_in = 1'b0;
    cmd_in    = 2'b00;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_matrix", 32'(matrix_out), 32'h1001);
    check_output("reset_valid", 32'(matrix_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_count", 32'(load_count), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // START latency: unchanged 3 edges after the rise, applied at the 4th.
    raise_strobe(CMD_START, 4'h0);
    repeat (3) @(posedge clk);
    #1 check_output("start_busy_3clk", 32'(busy), 32'd0);
    @(posedge clk);
    #1 check_output("start_busy_4clk", 32'(busy), 32'd1);
    release_strobe();

    // DATA latency on the first coefficient.
    raise_strobe(CMD_DATA, 4'h1);
    repeat (3) @(posedge clk);
    #1 check_output("data_count_3clk", 32'(load_count), 32'd0);
    @(posedge clk);
    #1 check_output("data_count_4clk", 32'(load_count), 32'd1);
    release_strobe();

    // Underflow commit: only two coefficients written.
    send(CMD_DATA, 4'h2);
    send(CMD_COMMIT, 4'h0);
    check_output("under_err", 32'(err), 32'd1);
    check_output("under_matrix", 32'(matrix_out), 32'h1001);
    check_output("under_busy", 32'(busy), 32'd0);
    check_output("under_valid", 32'(matrix_valid), 32'd0);
    check_output("under_count_hold", 32'(load_count), 32'd2);

    // START clears err and the counter, then a clean load of 3,5,7,9.
    send(CMD_START, 4'h0);
    check_output("restart_err", 32'(err), 32'd0);
    check_output("restart_count", 32'(load_count), 32'd0);
    send(CMD_DATA, 4'h3);
    send(CMD_DATA, 4'h5);
    send(CMD_DATA, 4'h7);
    send(CMD_DATA, 4'h9);
    check_output("load_count_full", 32'(load_count), 32'd4);
    check_output("load_matrix_pre", 32'(matrix_out), 32'h1001);
    send(CMD_COMMIT, 4'h0);
    check_output("commit_matrix", 32'(matrix_out), 32'h9753);
    check_output("commit_valid", 32'(matrix_valid), 32'd1);
    check_output("commit_busy", 32'(busy), 32'd0);
    check_output("commit_err", 32'(err), 32'd0);
    check_output("commit_count", 32'(load_count), 32'd4);

    // Overflow: fifth DATA flags err, commit still uses the first four.
    send(CMD_START, 4'h0);
    send(CMD_DATA, 4'h1);
    send(CMD_DATA, 4'h2);
    send(CMD_DATA, 4'h4);
    send(CMD_DATA, 4'h8);
    check_output("over_err_before", 32'(err), 32'd0);
    send(CMD_DATA, 4'hF);
    check_output("over_err", 32'(err), 32'd1);
    check_output("over_count", 32'(load_count), 32'd4);
    check_output("over_busy", 32'(busy), 32'd1);
    send(CMD_COMMIT, 4'h0);
    check_output("over_matrix", 32'(matrix_out), 32'h8421);
    check_output("over_err_sticky", 32'(err), 32'd1);

    // Reload 9753, then abort a partial load and commit from IDLE.
    send(CMD_START, 4'h0);
    send(CMD_DATA, 4'h3);
    send(CMD_DATA, 4'h5);
    send(CMD_DATA, 4'h7);
    send(CMD_DATA, 4'h9);
    send(CMD_COMMIT, 4'h0);
    check_output("reload_matrix", 32'(matrix_out), 32'h9753);
    send(CMD_START, 4'h0);
    send(CMD_DATA, 4'h1);
    send(CMD_DATA, 4'h1);
    send(CMD_ABORT, 4'h0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_matrix", 32'(matrix_out), 32'h9753);
    check_output("abort_err", 32'(err), 32'd0);
    check_output("abort_count", 32'(load_count), 32'd2);
    send(CMD_COMMIT, 4'h0);
    check_output("idle_commit_err", 32'(err), 32'd1);
    check_output("idle_commit_matrix", 32'(matrix_out), 32'h9753);

    // DATA in IDLE is ignored.
    send(CMD_DATA, 4'h6);
    check_output("idle_data_count", 32'(load_count), 32'd2);
    check_output("idle_data_err", 32'(err), 32'd1);

    // ena low: START discarded.
    ena = 1'b0;
    send(CMD_START, 4'h0);
    check_output("ena_off_busy", 32'(busy), 32'd0);
    check_output("ena_off_err", 32'(err), 32'd1);

    // Raising ena while the strobe is already high must not create an event.
    apply_stimulus(CMD_START, 4'h0);
    ena = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_output("ena_rise_busy", 32'(busy), 32'd0);
    check_output("ena_rise_err", 32'(err), 32'd1);
    release_strobe();

    // Asynchronous reset in the middle of a load.
    send(CMD_START, 4'h0);
    send(CMD_DATA, 4'h6);
    check_output("midload_busy", 32'(busy), 32'd1);
    check_output("midload_count", 32'(load_count), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_rst_matrix", 32'(matrix_out), 32'h1001);
    check_output("async_rst_valid", 32'(matrix_valid), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    check_output("async_rst_count", 32'(load_count), 32'd0);
    check_output("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Recovery: a full load after reset works again.
    send(CMD_START, 4'h0);
    send(CMD_DATA, 4'hA);
    send(CMD_DATA, 4'h0);
    send(CMD_DATA, 4'h0);
    send(CMD_DATA, 4'h5);
    send(CMD_COMMIT, 4'h0);
    check_output("recover_matrix", 32'(matrix_out), 32'h500A);
    check_output("recover_valid", 32'(matrix_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
